// File: rtl/enc_pkg.sv
// Shared definitions for the encoder output path: lane geometry, the
// lane-vector type and the packing rule that turns two lane sets into a word.
package enc_pkg;

    localparam int ENC_W     = 4;
    localparam int ENC_LANES = 4;
    localparam int WORD_W    = 2 * ENC_LANES * ENC_W;

    // One result set: lanes [0:ENC_LANES-1], each ENC_W bits wide.
    typedef logic [ENC_W-1:0] enc_vec_t [ENC_LANES];

    // Set 1 fills the low half of the word, set 2 the high half.
    // Lane 0 of each set sits in the least significant nibble of its half.
    function automatic logic [WORD_W-1:0] pack_enc(input enc_vec_t set1,
                                                   input enc_vec_t set2);
        logic [WORD_W-1:0] word;
        word = '0;
        for (int i = 0; i < ENC_LANES; i++) begin
            word[i*ENC_W +: ENC_W]               = set1[i];
            word[(ENC_LANES+i)*ENC_W +: ENC_W]   = set2[i];
        end
        return word;
    endfunction

endpackage

// File: rtl/enc_word_fifo.sv
// Show-ahead synchronous FIFO: the head entry is presented combinationally
// while the FIFO is non-empty, and the output reads as zero when empty.
// A push against a full FIFO with no simultaneous pop is dropped and flagged.
module enc_word_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 32,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count,
    output logic             o_drop
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_pop;
    logic w_push;

    // Qualify requests: a pop needs data, a push needs room (or a pop that
    // makes room in the same cycle). Clear overrides both.
    always_comb begin
        o_full  = (r_count == CNT_W'(DEPTH));
        o_empty = (r_count == '0);
        w_pop   = i_pop  & ~o_empty & ~i_clear;
        w_push  = i_push & (~o_full | w_pop) & ~i_clear;
        o_drop  = i_push & o_full & ~w_pop & ~i_clear;
        o_count = r_count;
        o_data  = o_empty ? '0 : r_mem[r_rd_ptr];
    end

    // Storage write; no reset needed because empty entries are never shown.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/enc_out_packer.sv
// Output packer behind the encoder output buffer: delays the buffer read
// strobe by one cycle to line up with the buffer's registered outputs,
// packs both lane sets into one word, queues it, and keeps a sticky flag
// for captures lost to a full queue.
module enc_out_packer
    import enc_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                buf_read_en_i,
    input  logic [ENC_W-1:0]    output_1_i [ENC_LANES],
    input  logic [ENC_W-1:0]    output_2_i [ENC_LANES],
    input  logic                clear_i,
    output logic                rd_valid_o,
    input  logic                rd_ready_i,
    output logic [WORD_W-1:0]   rd_data_o,
    output logic [CNT_W-1:0]    count_o,
    output logic                overflow_o
);

    logic              r_cap_en;
    logic              r_overflow;
    logic [WORD_W-1:0] w_word;
    logic              w_full;
    logic              w_empty;
    logic              w_drop;

    // The buffer output is valid one cycle after its read strobe, so the
    // strobe is delayed by one flop to become the capture enable.
    // Clear deliberately leaves this flop alone.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cap_en <= 1'b0;
        end else begin
            r_cap_en <= buf_read_en_i;
        end
    end

    // Packed form of the current buffer outputs, written when cap_en is high.
    always_comb begin
        w_word = pack_enc(output_1_i, output_2_i);
    end

    enc_word_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_clear (clear_i),
        .i_push  (r_cap_en),
        .i_data  (w_word),
        .i_pop   (rd_ready_i),
        .o_data  (rd_data_o),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count_o),
        .o_drop  (w_drop)
    );

    // Sticky overflow: set by a dropped capture, cleared only by clear/reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_overflow <= 1'b0;
        end else if (clear_i) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    assign rd_valid_o = ~w_empty;
    assign overflow_o = r_overflow;

    // A dropped capture can only ever happen against a full queue.
    drop_only_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
        w_drop |-> w_full);

endmodule

// File: tb/tb_enc_out_packer.sv
// Randomized bench for enc_out_packer with a queue-based reference model.
// The bench plays the role of the output buffer: data for a strobe issued in
// one cycle is presented on the lane inputs during the following cycle.
module tb_enc_out_packer;
    import enc_pkg::*;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        strobe;
    logic        clear;
    logic        ready;
    logic [3:0]  d1 [4];
    logic [3:0]  d2 [4];
    logic        valid;
    logic [31:0] data;
    logic [2:0]  count;
    logic        ovf;

    enc_out_packer #(.DEPTH(DEPTH)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .buf_read_en_i (strobe),
        .output_1_i    (d1),
        .output_2_i    (d2),
        .clear_i       (clear),
        .rd_valid_o    (valid),
        .rd_ready_i    (ready),
        .rd_data_o     (data),
        .count_o       (count),
        .overflow_o    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [31:0] q[$];
    bit          m_ovf;
    bit          m_cap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Word built from the lane values with plain arithmetic.
    function automatic logic [31:0] model_word();
        logic [31:0] w;
        w = 32'd0;
        for (int i = 0; i < 4; i++) begin
            w = w + (32'(d1[i]) * (32'd1 << (4 * i)));
            w = w + (32'(d2[i]) * (32'd1 << (16 + 4 * i)));
        end
        return w;
    endfunction

    function automatic void model_edge();
        bit cap_now;
        cap_now = m_cap;
        m_cap   = strobe;
        if (clear) begin
            q.delete();
            m_ovf = 0;
        end else begin
            bit popped;
            popped = ready && (q.size() > 0);
            if (popped) void'(q.pop_front());
            if (cap_now) begin
                if (q.size() < DEPTH) q.push_back(model_word());
                else m_ovf = 1;
            end
        end
    endfunction

    task automatic randomize_lanes();
        for (int i = 0; i < 4; i++) begin
            d1[i] = 4'($urandom_range(0, 15));
            d2[i] = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic check_outputs(input string phase);
        check({phase, "_valid"}, 32'(valid), 32'(q.size() > 0));
        check({phase, "_data"},  data, (q.size() > 0) ? q[0] : 32'd0);
        check({phase, "_count"}, 32'(count), 32'(q.size()));
        check({phase, "_ovf"},   32'(ovf), 32'(m_ovf));
    endtask

    // One clock: drive controls, take the edge, update model, compare.
    task automatic cycle(input string phase, input bit s, input bit r, input bit c);
        strobe = s;
        ready  = r;
        clear  = c;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(phase);
        randomize_lanes();
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic do_reset();
        @(negedge clk);
        #1;
        strobe = 0;
        clear  = 0;
        ready  = 0;
        rst    = 1;
        #1;
        check("arst_valid", 32'(valid), 32'd0);
        check("arst_data",  data, 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_ovf",   32'(ovf), 32'd0);
        q.delete();
        m_ovf = 0;
        m_cap = 0;
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        rst    = 1;
        strobe = 0;
        clear  = 0;
        ready  = 0;
        m_ovf  = 0;
        m_cap  = 0;
        randomize_lanes();
        repeat (2) @(negedge clk);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_data",  data, 32'd0);
        check("reset_count", 32'(count), 32'd0);
        check("reset_ovf",   32'(ovf), 32'd0);
        rst = 0;

        // Single word, known pattern, two-cycle latency
        cycle("t1", 1, 0, 0);
        d1 = '{4'd1, 4'd2, 4'd3, 4'd4};
        d2 = '{4'd5, 4'd6, 4'd7, 4'd8};
        cycle("t1", 0, 0, 0);
        check("t1_word",  data, 32'h8765_4321);
        check("t1_cnt1",  32'(count), 32'd1);
        cycle("t1", 0, 1, 0);
        check("t1_popped", 32'(valid), 32'd0);

        // Five strobes into a depth-4 queue: last is dropped
        for (int i = 0; i < 5; i++) cycle("t2", 1, 0, 0);
        cycle("t2", 0, 0, 0);
        check("t2_ovf_set", 32'(ovf), 32'd1);
        check("t2_cnt4",    32'(count), 32'd4);
        repeat (5) cycle("t2d", 0, 1, 0);
        check("t2_ovf_held", 32'(ovf), 32'd1);
        cycle("t2c", 0, 0, 1);

        // Full queue streaming: push and pop together every cycle
        for (int i = 0; i < 5; i++) cycle("t3f", 1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            cycle("t3", 1, 1, 0);
            check("t3_cnt_full", 32'(count), 32'd4);
            check("t3_no_ovf",   32'(ovf), 32'd0);
        end
        repeat (6) cycle("t3d", 0, 1, 0);

        // Eight interleaved pushes and pops to wrap the pointers
        for (int i = 0; i < 8; i++) cycle("t4", 1, (i % 2) == 1, 0);
        repeat (6) cycle("t4d", 0, 1, 0);

        // Clear coinciding with a capture while three words are queued
        for (int i = 0; i < 4; i++) cycle("t5f", 1, 0, 0);
        check("t5_cnt3", 32'(count), 32'd3);
        cycle("t5", 0, 0, 1);
        check("t5_cnt0",   32'(count), 32'd0);
        check("t5_valid0", 32'(valid), 32'd0);
        cycle("t5", 0, 0, 0);
        check("t5_absent", 32'(valid), 32'd0);

        // Asynchronous reset with two words queued and a capture pending
        for (int i = 0; i < 3; i++) cycle("t6f", 1, 0, 0);
        do_reset();
        cycle("t6", 1, 0, 0);
        cycle("t6", 0, 0, 0);
        check("t6_cnt1", 32'(count), 32'd1);
        cycle("t6", 0, 1, 0);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            cycle("rnd", ($urandom % 10) < 6, ($urandom % 2) == 1, ($urandom % 60) == 0);
        end
        repeat (6) cycle("rndd", 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/enc_out_packer.md
Name: enc_out_packer

Overview:
- Downstream stage of the encoder output buffer.
- Captures the two 4-lane x 4-bit encoder result sets that the buffer presents one cycle after a read strobe.
- Packs each capture into one 32-bit word and queues it in a small FIFO.
- Hands words to the CPU-side peripheral bus interface over a valid/ready handshake; flags overflow to software.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, at least 2.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count (derived, not overridden).

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- buf_read_en_i  in  1  same strobe driven to the output buffer's read enable.
- output_1_i  in  4 x [3:0]  buffer set-1 lanes [0:3].
- output_2_i  in  4 x [3:0]  buffer set-2 lanes [0:3].
- clear_i  in  1  synchronous flush of FIFO and overflow flag.
- rd_valid_o  out  1  FIFO head word valid.
- rd_ready_i  in  1  consumer accepts head word.
- rd_data_o  out  32  head word.
- count_o  out  CNT_W  current occupancy.
- overflow_o  out  1  sticky: a capture was dropped.

Behaviour:
- Reset (rst_i high, async): FIFO empty, rd_valid_o=0, rd_data_o=0, count_o=0, overflow_o=0, capture-delay register=0.
- Capture timing:
  - The buffer registers its outputs one cycle after buf_read_en_i.
  - The packer delays buf_read_en_i by one flop (cap_en).
  - Inputs are sampled on the edge where cap_en=1.
  - Back-to-back strobes give one capture per cycle.
- Packing: word[3:0]=output_1_i[0], [7:4]=output_1_i[1], [11:8]=output_1_i[2], [15:12]=output_1_i[3], [19:16]=output_2_i[0] ... [31:28]=output_2_i[3].
- Push: cap_en=1. Pop: rd_valid_o & rd_ready_i.
- FIFO read style: show-ahead. rd_data_o is the head entry whenever rd_valid_o=1, and 0 when empty.
- rd_valid_o = (count != 0).
- Word latency: buf_read_en_i at cycle N gives rd_valid_o=1 and the word at cycle N+2.
- Full with push and no pop: word dropped, FIFO unchanged, overflow_o set the next cycle and held until clear_i or reset.
- Full with push and pop in the same cycle: both happen, count unchanged, no overflow.
- Empty with push: word written. A pop is impossible while rd_valid_o=0.
- Pointers: log2(DEPTH) bits each, wrap naturally modulo DEPTH. count_o = occupancy, 0..DEPTH.
- clear_i: pointers and count go to 0 and overflow_o to 0 on the next edge. Clear has priority over push and pop in the same cycle, so that capture is discarded. The cap_en flop is not cleared.
- Reset mid-stream: all state drops immediately; no partial word survives.
- rd_data_o must stay stable while rd_valid_o=1 and rd_ready_i=0.

Decomposition:
- Package enc_pkg holds:
  - ENC_W=4 and ENC_LANES=4.
  - typedef enc_vec_t = logic [ENC_W-1:0] [ENC_LANES], plus WORD_W=32.
  - function pack_enc(set1, set2) returning WORD_W, which the encoder buffer side reuses.
- Sub-module enc_word_fifo: sync show-ahead FIFO with parameters DEPTH and WIDTH. It has push/pop/clear, full/empty/count, and a drop-on-full indication.
- enc_out_packer itself holds only the capture delay, packing and the sticky overflow flag.

Test Plan:
- Reset then strobe at cycle 0 with set1={1,2,3,4} and set2={5,6,7,8} (lanes 0..3) -> at cycle 2 rd_valid_o=1, rd_data_o=32'h8765_4321, count_o=1. With rd_ready_i=1 it pops and rd_valid_o=0 at cycle 3.
- Four consecutive strobes, rd_ready_i=0 -> count_o goes 1,2,3,4. A fifth strobe -> overflow_o=1, count_o stays 4. Draining returns the first four words in order.
- FIFO full, strobe held with rd_ready_i=1 continuously -> count_o stays 4, overflow_o stays 0, and words stream out in capture order at one per cycle.
- Eight pushes and pops interleaved -> pointers wrap correctly and data matches the scoreboard for all 8 words.
- clear_i asserted in the same cycle as a capture with count_o=3 -> next cycle count_o=0, rd_valid_o=0, overflow_o=0, and the captured word is absent.
- rst_i pulsed asynchronously mid-cycle with 2 words queued -> all outputs go to 0 immediately, without waiting for a clock edge. The first strobe after release produces a correct word.
